// File: rtl/array_proc_pkg.sv
// Shared types for the PE array command path: sequencer states, the
// instruction word layout and the readback widths.
package array_proc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_READ  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int INSTR_W    = 32;
   localparam int OPCODE_W   = 6;
   localparam int REG_FLD_W  = 5;
   localparam int RSVD_W     = 11;
   localparam int REG_ADDR_W = 10;
   localparam int DATA_W     = 16;

   localparam logic [OPCODE_W-1:0] OP_NOP = 6'd0;

   // Field order fixes the bit positions: opcode[31:26], rs[25:21],
   // rt[20:16], rd[15:11], rsvd[10:0].
   typedef struct packed {
      logic [OPCODE_W-1:0]  opcode;
      logic [REG_FLD_W-1:0] rs;
      logic [REG_FLD_W-1:0] rt;
      logic [REG_FLD_W-1:0] rd;
      logic [RSVD_W-1:0]    rsvd;
   } instr_t;

   function automatic logic is_nop(instr_t ins);
      return ins.opcode == OP_NOP;
   endfunction

endpackage

// File: rtl/pe_ack_tracker.sv
// Collects per-PE completion pulses into sticky bits. A clear in the same
// cycle as a pulse drops that pulse, so acks coincident with issue are lost.
module pe_ack_tracker
#(
   parameter int LENGTH = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [LENGTH-1:0] pe_ack,
   output logic              all_acked
);

   logic [LENGTH-1:0] seen_q, seen_d;

   // Accumulate pulses; clear has priority.
   always_comb begin
      seen_d = clr ? '0 : (seen_q | pe_ack);
   end

   // Sticky ack register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) seen_q <= '0;
      else        seen_q <= seen_d;
   end

   // Includes this cycle's pulses so the last ack can end the wait at once.
   assign all_acked = !clr && (&(seen_q | pe_ack));

endmodule

// File: rtl/pe_array_sequencer.sv
// Host-to-PE-array command sequencer: latch, broadcast, wait for all acks,
// read back one register from one PE, report with a done pulse.
//
// state | meaning
// IDLE  | waiting for a start rising edge
// ISSUE | one-cycle issue strobe, ack tracker cleared, timer loaded
// WAIT  | collecting acks; timer counts down to the timeout
// READ  | rd_req held until rd_valid, then data captured
// DONE  | one-cycle done pulse
module pe_array_sequencer
   import array_proc_pkg::*;
#(
   parameter int SIZE    = 5,
   parameter int LENGTH  = 32,
   parameter int TIMEOUT = 1024
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [INSTR_W-1:0]    instruction,
   input  logic [SIZE-1:0]       PE_Addr,
   input  logic [REG_ADDR_W-1:0] RegAddr,
   output logic [INSTR_W-1:0]    pe_instr,
   output logic                  pe_issue,
   input  logic [LENGTH-1:0]     pe_ack,
   output logic                  rd_req,
   output logic [SIZE-1:0]       rd_pe,
   output logic [REG_ADDR_W-1:0] rd_reg,
   input  logic                  rd_valid,
   input  logic [DATA_W-1:0]     rd_data,
   output logic [DATA_W-1:0]     data,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
   localparam logic [SIZE:0]    LEN_L    = (SIZE + 1)'(LENGTH);

   state_e                  state_q, state_d;
   logic                    start_q;
   instr_t                  instr_q, instr_d;
   logic [SIZE-1:0]         pe_q, pe_d;
   logic [REG_ADDR_W-1:0]   reg_q, reg_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic                    error_q, error_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic                    trk_clr;
   logic                    all_acked;
   logic                    start_edge;
   logic                    addr_oob;

   assign start_edge = start && !start_q;
   assign addr_oob   = {1'b0, PE_Addr} >= LEN_L;

   pe_ack_tracker #(.LENGTH(LENGTH)) u_tracker (
      .clk       (clk),
      .reset     (reset),
      .clr       (trk_clr),
      .pe_ack    (pe_ack),
      .all_acked (all_acked)
   );

   // Next-state and datapath updates; the wait timer is a down-counter
   // loaded in ISSUE and expiring at zero.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pe_d    = pe_q;
      reg_d   = reg_q;
      data_d  = data_q;
      error_d = error_q;
      tmr_d   = tmr_q;
      trk_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               instr_d = instruction;
               pe_d    = PE_Addr;
               reg_d   = RegAddr;
               error_d = addr_oob;
               state_d = addr_oob ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            trk_clr = 1'b1;
            tmr_d   = TMR_LOAD;
            state_d = is_nop(instr_q) ? ST_READ : ST_WAIT;
         end
         ST_WAIT: begin
            // Completion on the final timer cycle still counts as success.
            if (all_acked) begin
               state_d = ST_READ;
            end else if (tmr_q == '0) begin
               error_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_READ: begin
            if (rd_valid) begin
               data_d  = rd_data;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         instr_q <= '0;
         pe_q    <= '0;
         reg_q   <= '0;
         data_q  <= '0;
         error_q <= 1'b0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         instr_q <= instr_d;
         pe_q    <= pe_d;
         reg_q   <= reg_d;
         data_q  <= data_d;
         error_q <= error_d;
         tmr_q   <= tmr_d;
      end
   end

   assign pe_instr = instr_q;
   assign pe_issue = (state_q == ST_ISSUE);
   assign rd_req   = (state_q == ST_READ);
   assign rd_pe    = pe_q;
   assign rd_reg   = reg_q;
   assign data     = data_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign error    = error_q;

endmodule

// File: doc/pe_array_sequencer.md
# pe_array_sequencer

Command sequencer between the host-side control inputs and the processing-element (PE) array. On `start` it latches one 32-bit instruction, broadcasts it to every PE, and waits until all PEs acknowledge completion. It then reads one 16-bit register from one addressed PE and returns the value to the host with a `done` pulse. It owns the `start`/`instruction`/`PE_Addr`/`RegAddr`/`data` path at the top level.

## Interface
- `SIZE`, 5: PE address width.
- `LENGTH`, 32: number of PEs; must be ≤ 2^SIZE.
- `TIMEOUT`, 1024: maximum cycles to wait for PE acknowledges.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  command request (level; acted on at its rising edge).
- `instruction`  in  32  opcode[31:26], rs[25:21], rt[20:16], rd[15:11], rsvd[10:0].
- `PE_Addr`  in  SIZE  PE for readback.
- `RegAddr`  in  10  register address for readback.
- `pe_instr`  out  32  latched instruction broadcast to the array.
- `pe_issue`  out  1  one-cycle issue strobe.
- `pe_ack`  in  LENGTH  per-PE completion pulse.
- `rd_req`  out  1  readback request.
- `rd_pe`  out  SIZE  readback PE index.
- `rd_reg`  out  10  readback register.
- `rd_valid`  in  1  readback data valid.
- `rd_data`  in  16  readback data.
- `data`  out  16  captured result.
- `busy`  out  1  high from latch until done.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky; cleared by the next accepted start.

## Operation
- States: IDLE, ISSUE, WAIT, READ, DONE.
- IDLE: on a `start` rising edge (registered previous value 0, current value 1), latch `instruction`, `PE_Addr` and `RegAddr`, clear `error`, and go to ISSUE. Holding `start` high never retriggers.
- Latch-time address check: if `PE_Addr` ≥ LENGTH, set `error` and go to DONE. No issue occurs.
- ISSUE: drive `pe_issue`=1 for exactly one cycle and clear the ack tracker.
  - Opcode 0 (NOP): skip WAIT and go to READ.
  - Any other opcode: go to WAIT.
- WAIT: the tracker ORs `pe_ack` pulses into sticky bits. When all LENGTH bits are set, go to READ.
  - A timeout counter runs from 0. When it reaches TIMEOUT−1 with bits still missing, set `error` and go to DONE.
- READ: assert `rd_req` with `rd_pe`/`rd_reg` and hold them until `rd_valid`=1. On that cycle capture `rd_data` into `data` and go to DONE. READ has no timeout.
- DONE: `done`=1 for one cycle, then IDLE.
- `pe_instr` holds the latched instruction until the next accepted start.
- A `start` edge while not in IDLE is ignored and not queued.

## Timing
- Reset (asynchronous assert, synchronous release) forces all outputs and state to 0 / IDLE, including mid-operation: no further `pe_issue` and `rd_req` drops immediately.
- The `start` edge is sampled at cycle T. The latch happens at the T edge; `pe_issue` is high during cycle T+1.
- Acks arriving in the issue cycle are discarded (tracker clear wins). Acks from T+2 onward are counted.
- All acks present in cycle W → READ, with `rd_req` high in cycle W+1.
- `rd_valid` in cycle R → `data` updated and `done`=1 in cycle R+1.
- Minimum NOP latency: start edge → `done` = 3 cycles plus the readback wait.
- `busy` is high from T+1 through the DONE cycle inclusive.

## Structure
- Package `array_proc_pkg`:
  - state enum;
  - instruction field positions/widths;
  - `OP_NOP`=6'd0;
  - `REG_ADDR_W`=10 and `DATA_W`=16.
- Sub-module `pe_ack_tracker`:
  - LENGTH sticky bits;
  - synchronous clear input;
  - `all_acked` output.

## Test plan
- Reset held low, then released → all outputs 0, state IDLE. Assert reset mid-WAIT → `busy`/`rd_req` drop at once and no `done` is produced.
- Instruction 32'h08241800, PE_Addr=5'h11, RegAddr=10'h20, start rising edge → `pe_instr`=32'h08241800 and one `pe_issue`. All 32 acks returned staggered over 10 cycles, then `rd_pe`=17, `rd_reg`=32; `rd_data`=16'hBEEF → `data`=16'hBEEF, one `done` pulse, `error`=0.
- `start` held high for 1000 cycles → exactly one command executes.
- PE 7 never acks, TIMEOUT=1024 → `error`=1 and `done` exactly 1024 cycles after entering WAIT, no `rd_req`. The next start clears `error`.
- Opcode 0 with RegAddr=3 → no WAIT, `rd_req` two cycles after the start edge. Acks coincident with `pe_issue` are ignored: a PE acking only in the issue cycle causes a timeout.
- LENGTH=20, PE_Addr=25 → `error`=1, `done` pulse, no `pe_issue`.
